// File: rtl/cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded multi-digit counter.
package cascade_counter_pkg;

  localparam int unsigned DIGIT_W_DEFAULT = 4;
  localparam int unsigned MAX_DIGITS      = 8;
  localparam logic [3:0]  BCD_MAX         = 4'd9;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [MAX_DIGITS*DIGIT_W_DEFAULT-1:0] pack_digits(
    input logic [DIGIT_W_DEFAULT-1:0] d [MAX_DIGITS]
  );
    logic [MAX_DIGITS*DIGIT_W_DEFAULT-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      p[k*DIGIT_W_DEFAULT +: DIGIT_W_DEFAULT] = d[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/cascade_counter_digit.sv
// One digit cell: runtime modulus, up/down step, load and clear.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  // Up-terminal uses >= so a digit stranded above a lowered max still wraps.
  always_comb begin
    tc  = up ? (q_q >= max) : (q_q == '0);
    q_d = q_q;
    if (step) begin
      if (up) begin
        q_d = tc ? '0 : q_q + DIGIT_W'(1);
      end else begin
        q_d = tc ? max : q_q - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (clear) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= load_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cascade_counter.sv
// Cascaded multi-digit up/down counter with single-cycle carry chain,
// per-digit modulus, clamped parallel load and wrap-or-saturate mode.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned DIGIT_W    = DIGIT_W_DEFAULT,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] max_vec,
  input  logic                          enable,
  input  logic                          up,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic [NUM_DIGITS-1:0]         digit_tc,
  output logic                          tc,
  output logic                          wrap,
  output logic                          sat
);

  logic [NUM_DIGITS-1:0]         step;
  logic [NUM_DIGITS-1:0]         fixed;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_clamped;
  logic                          full_wrap;
  logic                          hold;
  logic                          changed;
  logic                          wrap_q, wrap_d;
  logic                          sat_q, sat_d;
  dir_e                          sat_dir_q, sat_dir_d;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [DIGIT_W-1:0] ld;
    logic [DIGIT_W-1:0] mx;
    logic [DIGIT_W-1:0] q;

    assign ld = load_data[g*DIGIT_W +: DIGIT_W];
    assign mx = max_vec[g*DIGIT_W +: DIGIT_W];
    assign load_clamped[g*DIGIT_W +: DIGIT_W] = (ld > mx) ? mx : ld;
    assign fixed[g] = (q == '0) && (mx == '0);

    counter_digit #(
      .DIGIT_W(DIGIT_W)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .load    (load),
      .load_val(load_clamped[g*DIGIT_W +: DIGIT_W]),
      .max     (mx),
      .step    (step[g]),
      .up      (up),
      .q       (q),
      .tc      (digit_tc[g])
    );

    assign count[g*DIGIT_W +: DIGIT_W] = q;
  end

  assign tc = &digit_tc;

  always_comb begin
    full_wrap = enable && tc;
    hold      = SATURATE && full_wrap;
    step[0]   = enable && !hold;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      step[i] = step[i-1] && digit_tc[i-1];
    end
  end

  // A stepped digit stays put only when it is 0 with max 0, in either direction.
  assign changed = |(step & ~fixed);

  always_comb begin
    wrap_d    = full_wrap && !SATURATE;
    sat_d     = sat_q;
    sat_dir_d = sat_dir_q;
    if (hold) begin
      sat_d     = 1'b1;
      sat_dir_d = dir_e'(up);
    end else if (sat_q && enable && (dir_e'(up) != sat_dir_q) && changed) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q    <= 1'b0;
      sat_q     <= 1'b0;
      sat_dir_q <= DIR_UP;
    end else if (clear || load) begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      wrap_q    <= wrap_d;
      sat_q     <= sat_d;
      sat_dir_q <= sat_dir_d;
    end
  end

  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule
